mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Round-robin controller that shares one sequential `multiplier` instance (start/finished handshake) between NUM_REQ requesters.
- Arbitrates requests, latches the granted requester's operands, and sequences the multiplier's start pulse and completion wait.
- Returns the product with a one-cycle done strobe to the owning requester.
- Sits between client FSMs and the multiplier; the multiplier is instantiated beside it, not inside.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IN_BITS, 8, operand width
OUT_BITS, 16, product width (≥ 2*IN_BITS)
TIMEOUT, 64, max cycles in WAIT before abort (only with optional feature)

Ports:
in_clk  in  1  clock, rising edge
in_rst  in  1  reset, asynchronous, active-low
in_req  in  NUM_REQ  per-requester request level
in_a  in  NUM_REQ*IN_BITS  packed operands a, requester i at [i*IN_BITS +: IN_BITS]
in_b  in  NUM_REQ*IN_BITS  packed operands b, same packing
out_grant  out  NUM_REQ  one-hot owner, high from grant to done inclusive
out_done  out  NUM_REQ  one-cycle completion strobe to owner
out_prod  out  OUT_BITS  last product, held until next done
out_busy  out  1  high in any state except IDLE
out_mult_start  out  1  start pulse to multiplier
out_mult_a  out  IN_BITS  latched operand a to multiplier
out_mult_b  out  IN_BITS  latched operand b to multiplier
in_mult_finished  in  1  multiplier finished flag
in_mult_prod  in  OUT_BITS  multiplier product

Behaviour:
- Reset (in_rst=0, async): state IDLE, all outputs 0, RR pointer 0, latched operands 0.
- States: IDLE → START → SETTLE → WAIT → DONE → IDLE.
- IDLE: if any in_req bit is set, select the first set bit at or above the pointer (wrapping); register one-hot out_grant and latch that requester's a/b; go to START.
- START: out_mult_start=1 for exactly one cycle; out_mult_a/b hold the latched values from START through DONE.
- SETTLE: one cycle; in_mult_finished ignored, since it may still be high from the previous op.
- WAIT: when in_mult_finished=1, register out_prod ← in_mult_prod and go to DONE.
- DONE: out_done[owner]=1 for one cycle; next cycle out_grant=0, pointer ← (owner+1) mod NUM_REQ, state IDLE.
- Latency: req sampled at edge k → mult start cycle k+1 → done cycle = multiplier latency + 3 minimum; at least 1 idle cycle between jobs.
- Requester holds in_req until its done strobe and drops it the next cycle. A request still high in IDLE is a new job, subject to round robin.
- Operands need be stable only in the grant cycle.
- Request dropped before grant: not served.
- Request dropped after grant: job completes, done still pulses, product still updates.
- Simultaneous requests: strictly round robin; no requester waits more than NUM_REQ-1 jobs.
- Reset mid-operation: immediate return to IDLE, grant/done/start cleared, out_prod cleared. The bench also resets the multiplier.
- Product width: in_mult_prod passed through unmodified; no truncation in this block.

Optional Feature:
- Macro: MULT_SHARE_TIMEOUT_EN.
- With it: a WAIT-cycle counter (width $clog2(TIMEOUT+1)) and an extra output `out_err` (1 bit) are compiled in.
  - Counter reaching TIMEOUT: go to DONE with out_prod=0 and out_err=1 for the done cycle.
  - out_err resets to 0.
- Without it: WAIT waits indefinitely; no counter and no out_err port.

Decomposition:
- Package `mult_share_pkg`: state enum type (IDLE, START, SETTLE, WAIT, DONE) and default constants for NUM_REQ, IN_BITS and OUT_BITS.
- Sub-module `rr_arbiter` (NUM_REQ):
  - Inputs: request vector, pointer.
  - Output: one-hot grant.
  - Purely combinational, reusable elsewhere.
- FSM, pointer register and operand mux stay in the top.

Test Plan:
- Single requester 0: a=123, b=234 → out_done[0] one cycle; out_prod=28782; out_grant[0] high grant→done; out_mult_start exactly one pulse.
- Max operands: requester 2 with 255*255 → out_prod=65025; 0*77 → 0.
- All four request in the same cycle with a=i+1, b=10 → service order 0,1,2,3; products 10,20,30,40; one done at a time; out_busy high throughout.
- After serving 1, requests 0 and 3 pending → 3 served before 0 (pointer wrap).
- in_rst=0 mid-WAIT → next edge: all outputs 0, IDLE. Re-request 12*12 → 144.
- Timeout (macro on, TIMEOUT=16), stub multiplier never finishing → done after 16 WAIT cycles; out_err=1; out_prod=0. Macro off → no done within 200 cycles.

Source files
------------

// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared types and default sizes for the multiplier-sharing
// controller. Imported by mult_share_ctrl.
package mult_share_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int IN_BITS_DEF  = 8;
  localparam int OUT_BITS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req  - request vector
//   ptr  - highest-priority index (search starts here, wraps)
//   gnt  - one-hot grant of the first set req bit at or above ptr, 0 if none
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;

  // one extra bit so ptr+off never overflows before the wrap subtract
  logic [SW-1:0] sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + SW'(off);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one sequential multiplier between NUM_REQ clients.
// Round-robin arbitration in IDLE, operands latched at grant, one-cycle start
// pulse, completion wait, then a one-cycle done strobe to the owner.
//
// Ports:
//   in_clk / in_rst          clock (rising), async active-low reset
//   in_req                   per-requester request levels
//   in_a / in_b              packed operands, requester i at [i*IN_BITS +: IN_BITS]
//   out_grant                one-hot owner, grant through done
//   out_done                 one-cycle completion strobe to owner
//   out_prod                 last product, held until next done
//   out_busy                 high whenever not IDLE
//   out_mult_start           start pulse to the multiplier
//   out_mult_a / out_mult_b  latched operands to the multiplier
//   in_mult_finished         multiplier finished flag
//   in_mult_prod             multiplier product
//   out_err                  (MULT_SHARE_TIMEOUT_EN only) timeout flag in done cycle
//
// Build option: define MULT_SHARE_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles (done with product 0 and out_err=1).
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
`ifdef MULT_SHARE_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic [NUM_REQ-1:0]          in_req,
  input  logic [NUM_REQ*IN_BITS-1:0]  in_a,
  input  logic [NUM_REQ*IN_BITS-1:0]  in_b,
  output logic [NUM_REQ-1:0]          out_grant,
  output logic [NUM_REQ-1:0]          out_done,
  output logic [OUT_BITS-1:0]         out_prod,
  output logic                        out_busy,
  output logic                        out_mult_start,
  output logic [IN_BITS-1:0]          out_mult_a,
  output logic [IN_BITS-1:0]          out_mult_b,
  input  logic                        in_mult_finished,
  input  logic [OUT_BITS-1:0]         in_mult_prod
`ifdef MULT_SHARE_TIMEOUT_EN
  , output logic                      out_err
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  state_t               state, nxt;
  logic [PW-1:0]        ptr, owner, nptr;
  logic [NUM_REQ-1:0]   arb_gnt, grant_q;
  logic [IN_BITS-1:0]   a_sel, b_sel, a_q, b_q;
  logic [OUT_BITS-1:0]  prod_q;
  logic                 tmo;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (in_req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // one-hot AND-OR operand select
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        a_sel = in_a[i*IN_BITS +: IN_BITS];
        b_sel = in_b[i*IN_BITS +: IN_BITS];
      end
    end
  end

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) owner = PW'(i);
  end

  assign nptr = (owner == PW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

`ifdef MULT_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] wcnt;
  logic          err_q;

  // wcnt counts completed WAIT cycles; abort in the cycle it would reach TIMEOUT
  assign tmo = (state == WAIT) && !in_mult_finished && (wcnt == CW'(TIMEOUT-1));

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
      if (tmo)                 err_q <= 1'b1;
      else if (state == DONE)  err_q <= 1'b0;
    end
  end

  assign out_err = err_q;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) state <= IDLE;
    else         state <= nxt;
  end

  // next state and strobes; SETTLE exists because finished may still be high
  // from the previous operation for a cycle after start
  always_comb begin
    nxt            = state;
    out_busy       = 1'b1;
    out_mult_start = 1'b0;
    out_done       = '0;
    case (state)
      IDLE: begin
        out_busy = 1'b0;
        if (|in_req) nxt = START;
      end
      START: begin
        out_mult_start = 1'b1;
        nxt            = SETTLE;
      end
      SETTLE: nxt = WAIT;
      WAIT:   if (in_mult_finished || tmo) nxt = DONE;
      DONE: begin
        out_done = grant_q;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        IDLE: if (|in_req) begin
          grant_q <= arb_gnt;
          a_q     <= a_sel;
          b_q     <= b_sel;
        end
        WAIT: begin
          if (in_mult_finished) prod_q <= in_mult_prod;
          else if (tmo)         prod_q <= '0;
        end
        DONE: begin
          grant_q <= '0;
          ptr     <= nptr;
        end
        default: ;
      endcase
    end
  end

  assign out_grant  = grant_q;
  assign out_prod   = prod_q;
  assign out_mult_a = a_q;
  assign out_mult_b = b_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed bench for mult_share_ctrl with a behavioural
// multiplier beside it (fixed latency, optional hang).
module tb_mult_share_ctrl;
  localparam int N = 4, IB = 8, OB = 16, MLAT = 4;

  logic            clk = 1'b0, rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*IB-1:0] a = '0, b = '0;
  logic [N-1:0]    grant, done;
  logic [OB-1:0]   prod;
  logic            busy, mstart;
  logic [IB-1:0]   ma, mb;
  logic            mfin;
  logic [OB-1:0]   mprod;
`ifdef MULT_SHARE_TIMEOUT_EN
  logic            err;
`endif

  always #5 clk = ~clk;

  mult_share_ctrl #(
    .NUM_REQ(N), .IN_BITS(IB), .OUT_BITS(OB)
`ifdef MULT_SHARE_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .in_clk(clk), .in_rst(rst), .in_req(req), .in_a(a), .in_b(b),
    .out_grant(grant), .out_done(done), .out_prod(prod), .out_busy(busy),
    .out_mult_start(mstart), .out_mult_a(ma), .out_mult_b(mb),
    .in_mult_finished(mfin), .in_mult_prod(mprod)
`ifdef MULT_SHARE_TIMEOUT_EN
    , .out_err(err)
`endif
  );

  // multiplier model: finished drops on start, rises MLAT+1 edges later
  int mcnt;
  bit mhang = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mfin <= 1'b0; mprod <= '0; mcnt <= 0;
    end else if (mstart) begin
      mfin <= 1'b0; mcnt <= MLAT;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !mhang) begin
        mfin  <= 1'b1;
        mprod <= OB'(ma) * OB'(mb);
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int            q_own[$];
  int            q_cyc[$];
  logic [OB-1:0] q_prod[$];
  logic          q_err[$];

  // raise requests r, collect n done strobes within budget cycles,
  // each requester dropping its req the cycle after its done
  task automatic run(input logic [N-1:0] r, input int n, input int budget, input string nm);
    int starts = 0, dones = 0, cyc = 0;
    logic [N-1:0] drop = '0;
    bit bad = 1'b0;
    q_own.delete(); q_cyc.delete(); q_prod.delete(); q_err.delete();
    @(negedge clk); req = req | r;
    while (dones < n && cyc < budget) begin
      @(negedge clk); cyc++;
      req  = req & ~drop;
      drop = '0;
      if (mstart) starts++;
      if (busy !== (grant != '0) || !$onehot0(grant)) bad = 1'b1;
      if (done != '0) begin
        if (!$onehot(done) || done !== grant) bad = 1'b1;
        for (int i = 0; i < N; i++) if (done[i]) q_own.push_back(i);
        q_cyc.push_back(cyc);
        q_prod.push_back(prod);
`ifdef MULT_SHARE_TIMEOUT_EN
        q_err.push_back(err);
`else
        q_err.push_back(1'b0);
`endif
        drop = done;
        dones++;
      end
    end
    check({nm, " completed"}, dones, n);
    @(negedge clk); req = req & ~drop;
    if (done != '0 || grant != '0) bad = 1'b1;
    if (mstart) starts++;
    check({nm, " start pulses"}, starts, n);
    check({nm, " grant/busy/done shape"}, {31'd0, bad}, 0);
  endtask

  function automatic int own(input int k);
    return (q_own.size() > k) ? q_own[k] : -1;
  endfunction

  function automatic logic [OB-1:0] prd(input int k);
    return (q_prod.size() > k) ? q_prod[k] : 'x;
  endfunction

  typedef struct {
    int            idx;
    logic [IB-1:0] va, vb;
    logic [OB-1:0] p;
  } vec_t;

  vec_t vt[5];
  int   dcount;

  initial begin
    vt[0] = '{0, 8'd123, 8'd234, 16'd28782};
    vt[1] = '{2, 8'd255, 8'd255, 16'd65025};
    vt[2] = '{2, 8'd0,   8'd77,  16'd0};
    vt[3] = '{1, 8'd12,  8'd12,  16'd144};
    vt[4] = '{3, 8'd200, 8'd3,   16'd600};

    // reset state
    repeat (2) @(negedge clk);
    check("rst grant", grant, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst start", mstart, 0);
    check("rst prod", prod, 0);
    check("rst mult_a", ma, 0);
    check("rst mult_b", mb, 0);
    rst = 1'b1;

    // single-requester vectors
    for (int v = 0; v < 5; v++) begin
      a[vt[v].idx*IB +: IB] = vt[v].va;
      b[vt[v].idx*IB +: IB] = vt[v].vb;
      run(N'(1) << vt[v].idx, 1, 40, $sformatf("vec%0d", v));
      check($sformatf("vec%0d owner", v), own(0), vt[v].idx);
      check($sformatf("vec%0d prod", v), prd(0), vt[v].p);
      if (v == 0) check("vec0 latency", q_cyc.size() > 0 ? q_cyc[0] : -1, 7);
    end

    // all four at once, pointer at 0
    a = {8'd4, 8'd3, 8'd2, 8'd1};
    b = {4{8'd10}};
    run(4'hF, 4, 200, "all4");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("all4 owner%0d", k), own(k), k);
      check($sformatf("all4 prod%0d", k), prd(k), OB'((k + 1) * 10));
    end

    // serve 1, then 0 and 3 pending: 3 comes before 0
    a[1*IB +: IB] = 8'd3; b[1*IB +: IB] = 8'd4;
    run(4'b0010, 1, 40, "wrap1");
    check("wrap1 prod", prd(0), 16'd12);
    a[0*IB +: IB] = 8'd5; b[0*IB +: IB] = 8'd6;
    a[3*IB +: IB] = 8'd7; b[3*IB +: IB] = 8'd8;
    run(4'b1001, 2, 100, "wrap");
    check("wrap first owner", own(0), 3);
    check("wrap first prod", prd(0), 16'd56);
    check("wrap second owner", own(1), 0);
    check("wrap second prod", prd(1), 16'd30);

    // reset while in WAIT
    mhang = 1'b1;
    a[2*IB +: IB] = 8'd9; b[2*IB +: IB] = 8'd9;
    @(negedge clk); req = 4'b0100;
    repeat (6) @(negedge clk);
    check("midwait busy", busy, 1);
    rst = 1'b0; req = '0;
    #1;
    check("midrst grant", grant, 0);
    check("midrst busy", busy, 0);
    check("midrst start", mstart, 0);
    check("midrst done", done, 0);
    check("midrst prod", prod, 0);
    @(negedge clk); rst = 1'b1; mhang = 1'b0;
    // pointer must be back at 0: requester 0 before 2
    a[0*IB +: IB] = 8'd12; b[0*IB +: IB] = 8'd12;
    run(4'b0101, 2, 100, "postrst");
    check("postrst first owner", own(0), 0);
    check("postrst first prod", prd(0), 16'd144);
    check("postrst second owner", own(1), 2);
    check("postrst second prod", prd(1), 16'd81);

    // multiplier that never finishes
    mhang = 1'b1;
    a[1*IB +: IB] = 8'd1; b[1*IB +: IB] = 8'd1;
`ifdef MULT_SHARE_TIMEOUT_EN
    run(4'b0010, 1, 60, "timeout");
    check("timeout owner", own(0), 1);
    check("timeout cycle", q_cyc.size() > 0 ? q_cyc[0] : -1, 19);
    check("timeout prod", prd(0), 0);
    check("timeout err", q_err.size() > 0 ? {31'd0, q_err[0]} : 32'd2, 1);
    check("timeout err cleared", err, 0);
`else
    dcount = 0;
    @(negedge clk); req = 4'b0010;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done != '0) dcount++;
    end
    check("hang no done", dcount, 0);
    check("hang busy", busy, 1);
    check("hang grant", grant, 4'b0010);
    rst = 1'b0; req = '0;
    @(negedge clk); rst = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
